// File: rtl/input_buffer_rc_if.sv
// ----------------------------------------------------------------------------
// input_buffer_rc_if
//   Bundles the upstream link and switch-allocator signals of one router
//   input port.
//
//   Handshake semantics (both directions):
//     Upstream -> buffer : a flit transfers on a clock edge where
//                          valid_in=1 and buf_full=0. buf_full is
//                          registered, so upstream must hold off while it
//                          is high; a flit offered while full is dropped.
//     Buffer -> allocator: the head flit transfers on a clock edge where
//                          valid_out=1 and ready=1. ready with valid_out=0
//                          has no effect.
//
//   Signals:
//     valid_in, data_in   upstream flit and its valid
//     buf_full            backpressure to upstream
//     ready               allocator grant; pops the head flit
//     valid_out, data_out head flit and its valid
//     label               XY route label of the head flit
//     flit_cnt            accepted (non-null) flit counter
//
//   Modports:
//     master : the router side (upstream link + allocator) driving the buffer
//     slave  : the input buffer itself
// ----------------------------------------------------------------------------
interface input_buffer_rc_if #(
  parameter int DATASIZE = 40
);
  logic                valid_in;
  logic [DATASIZE-1:0] data_in;
  logic                buf_full;
  logic                ready;
  logic                valid_out;
  logic [DATASIZE-1:0] data_out;
  logic [3:0]          label;
  logic [15:0]         flit_cnt;

  modport master (
    output valid_in, data_in, ready,
    input  buf_full, valid_out, data_out, label, flit_cnt
  );

  modport slave (
    input  valid_in, data_in, ready,
    output buf_full, valid_out, data_out, label, flit_cnt
  );
endinterface

// File: rtl/input_buffer_rc.sv
// ----------------------------------------------------------------------------
// input_buffer_rc
//   Per-direction input stage of the router. Incoming flits are stored in a
//   small FIFO together with their XY route label, which is computed from the
//   flit's destination at enqueue time. The head flit, its label and a valid
//   are presented to the switch allocator; the head is popped on ready.
//
//   Ports:
//     clk   router clock
//     rst   asynchronous, active-high reset
//     bus   input_buffer_rc_if.slave (valid_in/data_in/buf_full upstream,
//           ready/valid_out/data_out/label toward the allocator, flit_cnt)
//
//   Parameters:
//     DATASIZE  flit width; src[39:36] dst[35:32] ts[31:24] data[23:2] type[1:0]
//     DEPTH     FIFO entries (power of two, >= 2)
//     CUR_X/Y   coordinates of this router
//
//   Build option:
//     INPUT_BUF_FLITCNT_EN  when defined, flit_cnt counts stored flits
//                           (saturating at 16'hFFFF); otherwise it is 0.
//
//   Label encoding: 0=none 1=L 2=N 3=E 4=S 5=W.
// ----------------------------------------------------------------------------
module input_buffer_rc #(
  parameter int         DATASIZE = 40,
  parameter int         DEPTH    = 4,
  parameter logic [1:0] CUR_X    = 2'd0,
  parameter logic [1:0] CUR_Y    = 2'd0
) (
  input  logic              clk,
  input  logic              rst,
  input_buffer_rc_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATASIZE + 4;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [3:0] LBL_L = 4'd1;
  localparam logic [3:0] LBL_N = 4'd2;
  localparam logic [3:0] LBL_E = 4'd3;
  localparam logic [3:0] LBL_S = 4'd4;
  localparam logic [3:0] LBL_W = 4'd5;

  // X-first dimension-ordered routing. Y grows toward S.
  function automatic logic [3:0] xy_label(input logic [3:0] dst);
    logic [1:0] dst_x;
    logic [1:0] dst_y;
    dst_x = dst[3:2];
    dst_y = dst[1:0];
    if (dst_x > CUR_X)      return LBL_E;
    else if (dst_x < CUR_X) return LBL_W;
    else if (dst_y > CUR_Y) return LBL_S;
    else if (dst_y < CUR_Y) return LBL_N;
    else                    return LBL_L;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          buf_full_q, buf_full_d;
  logic [EW-1:0] mem_q [DEPTH];

  // --------------------------------------------------------------------------
  // Enqueue side
  // --------------------------------------------------------------------------
  logic [3:0] label_in;
  logic       push;
  logic       store;
  logic       pop;
  logic       valid_out;

  assign label_in = xy_label(bus.data_in[DATASIZE-5:DATASIZE-8]);

  // A push is consumed whenever the port is not full; null flits
  // (type==2'b00) are consumed without occupying an entry.
  assign push  = bus.valid_in && !buf_full_q;
  assign store = push && (bus.data_in[1:0] != 2'b00);

  assign valid_out = (count_q != '0);
  assign pop       = valid_out && bus.ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (store) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({store, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // Full is registered from the next count, so a pop while full only
    // opens the port on the following cycle.
    buf_full_d = (count_d == FULL_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      buf_full_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      buf_full_q <= buf_full_d;
    end
  end

  // Storage is not reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= {label_in, bus.data_in};
  end

  // --------------------------------------------------------------------------
  // Dequeue side: combinational head read, forced to 0 when empty so that
  // an asynchronous reset clears data_out/label immediately.
  // --------------------------------------------------------------------------
  logic [EW-1:0] head;

  always_comb begin
    head = '0;
    if (valid_out) head = mem_q[rd_ptr_q];
  end

  assign bus.valid_out = valid_out;
  assign bus.buf_full  = buf_full_q;
  assign bus.data_out  = head[DATASIZE-1:0];
  assign bus.label     = head[EW-1:DATASIZE];

  // --------------------------------------------------------------------------
  // Accepted-flit counter
  // --------------------------------------------------------------------------
`ifdef INPUT_BUF_FLITCNT_EN
  logic [15:0] flit_cnt_q, flit_cnt_d;

  always_comb begin
    flit_cnt_d = flit_cnt_q;
    if (store && (flit_cnt_q != 16'hFFFF)) flit_cnt_d = flit_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flit_cnt_q <= 16'd0;
    else     flit_cnt_q <= flit_cnt_d;
  end

  assign bus.flit_cnt = flit_cnt_q;
`else
  assign bus.flit_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_input_buffer_rc.sv
// ----------------------------------------------------------------------------
// tb_input_buffer_rc
//   Directed + random bench for input_buffer_rc with CUR_X=1, CUR_Y=1,
//   DEPTH=4. Expected {label, flit} pairs are queued when a flit is stored
//   and compared when the head is popped.
// ----------------------------------------------------------------------------
module tb_input_buffer_rc;

  localparam int DW    = 40;
  localparam int DEPTH = 4;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  input_buffer_rc_if #(.DATASIZE(DW)) bus ();

  input_buffer_rc #(
    .DATASIZE (DW),
    .DEPTH    (DEPTH),
    .CUR_X    (2'd1),
    .CUR_Y    (2'd1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  logic [DW+3:0] exp_q[$];
  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [15:0]   exp_cnt = 16'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent XY reference for CUR_X=1, CUR_Y=1.
  function automatic logic [3:0] ref_label(input logic [3:0] dst);
    int x, y;
    x = int'(dst[3:2]);
    y = int'(dst[1:0]);
    if (x > 1)      return 4'd3;
    else if (x < 1) return 4'd5;
    else if (y > 1) return 4'd4;
    else if (y < 1) return 4'd2;
    else            return 4'd1;
  endfunction

  function automatic logic [DW-1:0] mk(input logic [3:0] dst, input logic [1:0] typ,
                                       input logic [21:0] payload);
    return {4'hA, dst, 8'h5C, payload, typ};
  endfunction

  // --------------------------------------------------------------------------
  // Driver: called just after a falling edge. Checks the visible state,
  // applies inputs for the next rising edge, updates the model, and
  // advances to the next falling edge.
  // --------------------------------------------------------------------------
  task automatic cycle(input logic vin, input logic [DW-1:0] din, input logic rdy);
    logic accept;
    check("valid_out", 64'(bus.valid_out), 64'(exp_q.size() != 0));
    check("buf_full",  64'(bus.buf_full),  64'(exp_q.size() == DEPTH));
    check("flit_cnt",  64'(bus.flit_cnt),  64'(exp_cnt));
    if (exp_q.size() == 0) begin
      check("empty_data",  64'(bus.data_out), 64'(0));
      check("empty_label", 64'(bus.label),    64'(0));
    end
    bus.valid_in = vin;
    bus.data_in  = din;
    bus.ready    = rdy;
    accept = vin && (exp_q.size() != DEPTH);
    if (rdy && exp_q.size() != 0) begin
      check("head", 64'({bus.label, bus.data_out}), 64'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    if (accept && din[1:0] != 2'b00) begin
      exp_q.push_back({ref_label(din[35:32]), din});
`ifdef INPUT_BUF_FLITCNT_EN
      if (exp_cnt != 16'hFFFF) exp_cnt++;
`endif
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.ready    = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    bus.ready    = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_valid_out", 64'(bus.valid_out), 64'(0));
    check("rst_buf_full",  64'(bus.buf_full),  64'(0));
    check("rst_label",     64'(bus.label),     64'(0));
    check("rst_data_out",  64'(bus.data_out),  64'(0));
    check("rst_flit_cnt",  64'(bus.flit_cnt),  64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Single flit routed East, then popped.
    cycle(1'b1, mk(4'b1001, 2'b01, 22'h00011), 1'b0);
    check("label_E", 64'(bus.label), 64'(3));
    cycle(1'b0, '0, 1'b1);
    check("popped_valid", 64'(bus.valid_out), 64'(0));
    check("popped_label", 64'(bus.label),     64'(0));

    // Fill with L, N, W, S; fifth flit arrives while full and is dropped.
    cycle(1'b1, mk(4'b0101, 2'b01, 22'h00101), 1'b0);
    cycle(1'b1, mk(4'b0100, 2'b10, 22'h00102), 1'b0);
    cycle(1'b1, mk(4'b0001, 2'b11, 22'h00103), 1'b0);
    cycle(1'b1, mk(4'b0110, 2'b01, 22'h00104), 1'b0);
    check("full_after_4", 64'(bus.buf_full), 64'(1));
    cycle(1'b1, mk(4'b1111, 2'b01, 22'h3DEAD), 1'b0);
    check("head_L", 64'(bus.label), 64'(1));
    cycle(1'b0, '0, 1'b1);
    check("head_N", 64'(bus.label), 64'(2));
    cycle(1'b0, '0, 1'b1);
    check("head_W", 64'(bus.label), 64'(5));
    cycle(1'b0, '0, 1'b1);
    check("head_S", 64'(bus.label), 64'(4));
    cycle(1'b0, '0, 1'b1);

    // Simultaneous push and pop at count=2 (pointers now well past a wrap).
    cycle(1'b1, mk(4'b1100, 2'b01, 22'h00201), 1'b0);
    cycle(1'b1, mk(4'b0011, 2'b10, 22'h00202), 1'b0);
    cycle(1'b1, mk(4'b1010, 2'b11, 22'h00203), 1'b1);
    check("pushpop_full", 64'(bus.buf_full), 64'(0));
    // Fill, then push+pop while full: pop happens, push dropped.
    cycle(1'b1, mk(4'b0000, 2'b01, 22'h00204), 1'b0);
    cycle(1'b1, mk(4'b0111, 2'b01, 22'h00205), 1'b0);
    check("full_again", 64'(bus.buf_full), 64'(1));
    cycle(1'b1, mk(4'b1101, 2'b01, 22'h3BEEF), 1'b1);
    check("full_pop_release", 64'(bus.buf_full), 64'(0));
    repeat (4) cycle(1'b0, '0, 1'b1);

    // Null flit: not stored, not counted.
    cycle(1'b1, mk(4'b1001, 2'b00, 22'h00300), 1'b0);
    check("null_valid", 64'(bus.valid_out), 64'(0));
    cycle(1'b1, mk(4'b0001, 2'b01, 22'h00301), 1'b0);
    cycle(1'b1, mk(4'b0010, 2'b10, 22'h00302), 1'b0);
    cycle(1'b1, mk(4'b1110, 2'b11, 22'h00303), 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      cycle(1'($urandom_range(0, 1)),
            mk(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
               22'($urandom_range(0, 22'h3FFFFF))),
            1'($urandom_range(0, 1)));
    end
    while (exp_q.size() != 0) cycle(1'b0, '0, 1'b1);

    // Asynchronous reset with 3 flits buffered.
    cycle(1'b1, mk(4'b1001, 2'b01, 22'h00401), 1'b0);
    cycle(1'b1, mk(4'b0100, 2'b01, 22'h00402), 1'b0);
    cycle(1'b1, mk(4'b0110, 2'b01, 22'h00403), 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid_out", 64'(bus.valid_out), 64'(0));
    check("arst_buf_full",  64'(bus.buf_full),  64'(0));
    check("arst_label",     64'(bus.label),     64'(0));
    check("arst_data_out",  64'(bus.data_out),  64'(0));
    check("arst_flit_cnt",  64'(bus.flit_cnt),  64'(0));
    exp_q.delete();
    exp_cnt = 16'd0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, mk(4'b0001, 2'b10, 22'h00500), 1'b0);
    check("post_rst_label", 64'(bus.label), 64'(5));
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
